// File: rtl/multdiv_ctrl.sv
// Issue/writeback sequencer between the pipeline and the shared multdiv unit.
// One request in flight at a time; results are held until the pipeline consumes them.
module multdiv_ctrl #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_div,
  input  logic [31:0] req_opA,
  input  logic [31:0] req_opB,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_exception
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_DONE,
    S_DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   opa_q, opa_d;
  logic [31:0]   opb_q, opb_d;
  logic [4:0]    rd_q, rd_d;
  logic          is_div_q, is_div_d;
  logic [31:0]   res_q, res_d;
  logic          exc_q, exc_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      rd_q     <= '0;
      is_div_q <= 1'b0;
      res_q    <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      rd_q     <= rd_d;
      is_div_q <= is_div_d;
      res_q    <= res_d;
      exc_q    <= exc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    rd_d     = rd_q;
    is_div_d = is_div_q;
    res_d    = res_q;
    exc_d    = exc_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          opa_d    = req_opA;
          opb_d    = req_opB;
          rd_d     = req_rd;
          is_div_d = req_is_div;
          state_d  = S_START;
        end
      end
      S_START: begin
        // Any resultRDY seen here belongs to an earlier operation and is ignored.
        cnt_d   = '0;
        state_d = flush ? S_DRAIN : S_BUSY;
      end
      S_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (flush) begin
          state_d = S_DRAIN;
        end else if (md_resultRDY) begin
          res_d   = md_result;
          exc_d   = md_exception;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          res_d   = '0;
          exc_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (flush || wb_ready) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        // Counting continues from BUSY so the drain is bounded by the same timeout.
        cnt_d = cnt_q + 1'b1;
        if (md_resultRDY || cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign md_operandA  = opa_q;
  assign md_operandB  = opb_q;
  assign md_ctrl_MULT = (state_q == S_START) && !is_div_q;
  assign md_ctrl_DIV  = (state_q == S_START) &&  is_div_q;
  assign wb_valid     = (state_q == S_DONE);
  assign wb_data      = res_q;
  assign wb_rd        = rd_q;
  assign wb_exception = exc_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl; the bench plays the multdiv unit and the pipeline.
module tb_multdiv_ctrl;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_div;
  logic [31:0] req_opA;
  logic [31:0] req_opB;
  logic [4:0]  req_rd;
  logic        flush;
  logic        busy;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_exception;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        exc;
  } wb_exp_t;

  wb_exp_t sb[$];
  int unsigned checks = 0;
  int unsigned failures = 0;

  multdiv_ctrl #(.TIMEOUT(40)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_div   (req_is_div),
    .req_opA      (req_opA),
    .req_opB      (req_opB),
    .req_rd       (req_rd),
    .flush        (flush),
    .busy         (busy),
    .md_operandA  (md_operandA),
    .md_operandB  (md_operandB),
    .md_ctrl_MULT (md_ctrl_MULT),
    .md_ctrl_DIV  (md_ctrl_DIV),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_resultRDY (md_resultRDY),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_data      (wb_data),
    .wb_rd        (wb_rd),
    .wb_exception (wb_exception)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input wb_exp_t e);
    chk1({tag, "_valid"}, wb_valid, 1'b1);
    chk32({tag, "_data"}, wb_data, e.data);
    chk32({tag, "_rd"}, {27'd0, wb_rd}, {27'd0, e.rd});
    chk1({tag, "_exc"}, wb_exception, e.exc);
  endtask

  // Accepts a request in IDLE and ends one cycle into BUSY.
  task automatic issue(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic stale_rdy);
    chk1("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_is_div = is_div; req_opA = a; req_opB = b; req_rd = rd;
    tick();
    req_valid = 1'b0; req_is_div = ~is_div;
    req_opA = 32'hDEAD_BEEF; req_opB = 32'hBAD0_F00D; req_rd = 5'd31;
    chk1("busy_start", busy, 1'b1);
    chk1("req_ready_start", req_ready, 1'b0);
    chk1("mult_pulse", md_ctrl_MULT, ~is_div);
    chk1("div_pulse", md_ctrl_DIV, is_div);
    chk32("operandA", md_operandA, a);
    chk32("operandB", md_operandB, b);
    if (stale_rdy) begin
      md_resultRDY = 1'b1; md_result = 32'h5555_AAAA; md_exception = 1'b1;
    end
    tick();
    md_resultRDY = 1'b0; md_exception = 1'b0;
    chk1("mult_pulse_end", md_ctrl_MULT, 1'b0);
    chk1("div_pulse_end", md_ctrl_DIV, 1'b0);
    chk1("stale_rdy_no_wb", wb_valid, 1'b0);
    chk32("operandA_held", md_operandA, a);
    chk32("operandB_held", md_operandB, b);
  endtask

  task automatic respond(input int unsigned wait_cyc, input logic [31:0] res, input logic exc);
    for (int unsigned i = 0; i < wait_cyc; i++) begin
      tick();
      chk1("busy_no_wb", wb_valid, 1'b0);
      chk1("busy_held", busy, 1'b1);
    end
    md_resultRDY = 1'b1; md_result = res; md_exception = exc;
    tick();
    md_resultRDY = 1'b0; md_result = 32'h0F0F_0F0F; md_exception = ~exc;
    chk1("wb_valid_after_rdy", wb_valid, 1'b1);
  endtask

  task automatic consume(input int unsigned hold);
    wb_exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL sb_underflow observed=%0d expected=%0d", sb.size(), 1);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      for (int unsigned i = 0; i < hold; i++) begin
        chk_wb("wb_hold", e);
        chk1("req_blocked_done", req_ready, 1'b0);
        req_valid = 1'b1; req_opA = i;
        tick();
      end
      chk_wb("wb", e);
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0; req_valid = 1'b0;
      chk1("wb_gone", wb_valid, 1'b0);
      chk1("ready_after_wb", req_ready, 1'b1);
      chk1("idle_after_wb", busy, 1'b0);
    end
  endtask

  initial begin
    wb_exp_t e;
    int pa, pb;
    reset = 1'b1; req_valid = 1'b0; req_is_div = 1'b0; req_opA = '0; req_opB = '0;
    req_rd = '0; flush = 1'b0; md_result = '0; md_exception = 1'b0;
    md_resultRDY = 1'b0; wb_ready = 1'b0;
    tick(); tick();
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk1("rst_mult", md_ctrl_MULT, 1'b0);
    chk1("rst_div", md_ctrl_DIV, 1'b0);
    chk32("rst_opA", md_operandA, 32'h0);
    chk32("rst_wb_data", wb_data, 32'h0);
    reset = 1'b0;
    tick();
    chk1("post_rst_ready", req_ready, 1'b1);

    // mult 7 * -6 -> -42, stale RDY during START, writeback held 2 cycles
    pa = 7; pb = -6;
    sb.push_back('{data: 32'(pa * pb), rd: 5'd3, exc: 1'b0});
    issue(1'b0, 32'(pa), 32'(pb), 5'd3, 1'b1);
    respond(3, 32'(pa * pb), 1'b0);
    consume(2);

    // div by zero, exception propagated
    sb.push_back('{data: 32'h0, rd: 5'd5, exc: 1'b1});
    issue(1'b1, 32'd100, 32'd0, 5'd5, 1'b0);
    respond(6, 32'h0, 1'b1);
    consume(0);

    // timeout: 40 BUSY cycles with no RDY
    sb.push_back('{data: 32'h0, rd: 5'd9, exc: 1'b1});
    md_result = 32'h1234_5678;
    issue(1'b0, 32'd3, 32'd4, 5'd9, 1'b0);
    for (int unsigned i = 0; i < 39; i++) tick();
    chk1("timeout_boundary", wb_valid, 1'b0);
    tick();
    chk1("timeout_wb", wb_valid, 1'b1);
    consume(0);

    // flush 5 cycles into BUSY, RDY arrives later and is discarded
    issue(1'b0, 32'd2, 32'd3, 5'd7, 1'b0);
    for (int unsigned i = 0; i < 5; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      chk1("drain_busy", busy, 1'b1);
      chk1("drain_no_wb", wb_valid, 1'b0);
      chk1("drain_not_ready", req_ready, 1'b0);
      tick();
    end
    md_resultRDY = 1'b1; md_result = 32'd6;
    tick();
    md_resultRDY = 1'b0;
    chk1("drain_done_ready", req_ready, 1'b1);
    chk1("drain_done_no_wb", wb_valid, 1'b0);

    // new request accepted right after drain; RDY on first BUSY cycle
    pa = -3; pb = -5;
    sb.push_back('{data: 32'(pa * pb), rd: 5'd30, exc: 1'b0});
    issue(1'b0, 32'(pa), 32'(pb), 5'd30, 1'b0);
    respond(0, 32'(pa * pb), 1'b0);
    consume(1);

    // flush beats RDY in the same BUSY cycle
    issue(1'b1, 32'd9, 32'd3, 5'd1, 1'b0);
    flush = 1'b1; md_resultRDY = 1'b1; md_result = 32'd3;
    tick();
    flush = 1'b0; md_resultRDY = 1'b0;
    chk1("flush_beats_rdy_busy", busy, 1'b1);
    chk1("flush_beats_rdy_no_wb", wb_valid, 1'b0);
    md_resultRDY = 1'b1;
    tick();
    md_resultRDY = 1'b0;
    chk1("flush_beats_rdy_idle", req_ready, 1'b1);

    // flush in the accept cycle blocks acceptance
    req_valid = 1'b1; flush = 1'b1; req_opA = 32'd77;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    chk1("flush_accept_ready", req_ready, 1'b1);
    chk1("flush_accept_mult", md_ctrl_MULT, 1'b0);
    chk1("flush_accept_div", md_ctrl_DIV, 1'b0);

    // wb_ready together with flush in DONE
    issue(1'b1, 32'd50, 32'd7, 5'd12, 1'b0);
    respond(2, 32'd7, 1'b0);
    e = '{data: 32'd7, rd: 5'd12, exc: 1'b0};
    chk_wb("done_flush", e);
    wb_ready = 1'b1; flush = 1'b1;
    tick();
    wb_ready = 1'b0; flush = 1'b0;
    chk1("done_flush_idle", req_ready, 1'b1);
    chk1("done_flush_no_wb", wb_valid, 1'b0);

    // reset in BUSY, later RDY ignored
    issue(1'b0, 32'd11, 32'd13, 5'd4, 1'b0);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("rst_busy_ready", req_ready, 1'b1);
    chk1("rst_busy_idle", busy, 1'b0);
    chk1("rst_busy_no_wb", wb_valid, 1'b0);
    chk1("rst_busy_mult", md_ctrl_MULT, 1'b0);
    chk32("rst_busy_opA", md_operandA, 32'h0);
    md_resultRDY = 1'b1; md_result = 32'd143;
    tick();
    md_resultRDY = 1'b0;
    chk1("rst_late_rdy_no_wb", wb_valid, 1'b0);
    chk1("rst_late_rdy_ready", req_ready, 1'b1);
    tick();
    chk1("rst_late_rdy_still_idle", busy, 1'b0);

    chk32("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
